// File: rtl/pcie_tx_scrambler.sv
// PCIe Gen1/Gen2 single-lane TX scrambler (G(x)=x^16+x^5+x^4+x^3+1) with a 2-entry skid buffer.
// Define PCIE_TX_SCRAMBLER_DBG_EN to expose the live LFSR state on lfsr_dbg_o.
module pcie_tx_scrambler #(
  parameter logic [15:0] LFSR_SEED = 16'hFFFF
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        bypass_scrambler_i,
  input  logic [7:0]  data_i,
  input  logic        k_i,
  input  logic        valid_i,
  output logic        ready_o,
  output logic [7:0]  data_o,
  output logic        k_o,
  output logic        valid_o,
  input  logic        ready_i
`ifdef PCIE_TX_SCRAMBLER_DBG_EN
  ,
  output logic [15:0] lfsr_dbg_o
`endif
);

  localparam int unsigned DataW = 8;
  localparam int unsigned LfsrW = 16;
  localparam logic [DataW-1:0] SymCom = 8'hBC;
  localparam logic [DataW-1:0] SymSkp = 8'h1C;
  localparam logic [LfsrW-1:0] LfsrPoly = 16'h0039;

  logic [LfsrW-1:0] lfsr_q, lfsr_d, lfsr_adv;
  logic [DataW-1:0] scr_bits;
  logic [DataW-1:0] in_data;
  logic             is_com, is_skp;
  logic             in_xfer, out_xfer;

  logic [DataW-1:0] e0_data_q, e0_data_d, e1_data_q, e1_data_d;
  logic             e0_k_q, e0_k_d, e1_k_q, e1_k_d;
  logic             e0_vld_q, e0_vld_d, e1_vld_q, e1_vld_d;

  assign in_xfer  = valid_i && ready_o;
  assign out_xfer = e0_vld_q && ready_i;
  assign is_com   = k_i && (data_i == SymCom);
  assign is_skp   = k_i && (data_i == SymSkp);

  // Serial LFSR unrolled 8 times; bit i of the keystream is lfsr[15] before step i.
  always_comb begin
    lfsr_adv = lfsr_q;
    scr_bits = '0;
    for (int i = 0; i < int'(DataW); i++) begin
      scr_bits[i] = lfsr_adv[LfsrW-1];
      lfsr_adv    = {lfsr_adv[LfsrW-2:0], 1'b0} ^ (lfsr_adv[LfsrW-1] ? LfsrPoly : '0);
    end
  end

  // K symbols and bypassed bytes pass through; the LFSR sequencing is unaffected by bypass.
  always_comb begin
    in_data = (k_i || bypass_scrambler_i) ? data_i : (data_i ^ scr_bits);
    lfsr_d  = lfsr_q;
    if (in_xfer) begin
      if (is_com) begin
        lfsr_d = LFSR_SEED;
      end else if (!is_skp) begin
        lfsr_d = lfsr_adv;
      end
    end
  end

  // Skid buffer: entry 0 feeds the outputs, entry 1 catches the byte accepted during a stall.
  always_comb begin
    e0_data_d = e0_data_q;
    e0_k_d    = e0_k_q;
    e0_vld_d  = e0_vld_q;
    e1_data_d = e1_data_q;
    e1_k_d    = e1_k_q;
    e1_vld_d  = e1_vld_q;
    if (e1_vld_q) begin
      if (out_xfer) begin
        e0_data_d = e1_data_q;
        e0_k_d    = e1_k_q;
        e1_vld_d  = 1'b0;
      end
    end else if (!e0_vld_q || out_xfer) begin
      if (in_xfer) begin
        e0_data_d = in_data;
        e0_k_d    = k_i;
      end
      e0_vld_d = in_xfer;
    end else if (in_xfer) begin
      e1_data_d = in_data;
      e1_k_d    = k_i;
      e1_vld_d  = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      lfsr_q    <= LFSR_SEED;
      e0_data_q <= '0;
      e0_k_q    <= 1'b0;
      e0_vld_q  <= 1'b0;
      e1_data_q <= '0;
      e1_k_q    <= 1'b0;
      e1_vld_q  <= 1'b0;
    end else begin
      lfsr_q    <= lfsr_d;
      e0_data_q <= e0_data_d;
      e0_k_q    <= e0_k_d;
      e0_vld_q  <= e0_vld_d;
      e1_data_q <= e1_data_d;
      e1_k_q    <= e1_k_d;
      e1_vld_q  <= e1_vld_d;
    end
  end

  assign ready_o = ~e1_vld_q;
  assign data_o  = e0_data_q;
  assign k_o     = e0_k_q;
  assign valid_o = e0_vld_q;

`ifdef PCIE_TX_SCRAMBLER_DBG_EN
  assign lfsr_dbg_o = lfsr_q;
`endif

endmodule

// File: tb/tb_pcie_tx_scrambler.sv
// Scoreboard bench for pcie_tx_scrambler: a reference LFSR model predicts each accepted byte,
// and fixed vectors pin down the known keystream values.
module tb_pcie_tx_scrambler;

  localparam logic [15:0] SEED = 16'hFFFF;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic       bypass_scrambler_i = 1'b0;
  logic [7:0] data_i = 8'h00;
  logic       k_i = 1'b0;
  logic       valid_i = 1'b0;
  logic       ready_o;
  logic [7:0] data_o;
  logic       k_o;
  logic       valid_o;
  logic       ready_i = 1'b1;
`ifdef PCIE_TX_SCRAMBLER_DBG_EN
  logic [15:0] lfsr_dbg_o;
`endif

  int checks = 0;
  int errors = 0;

  logic [8:0]  sb_q[$];
  logic [8:0]  log_q[$];
  logic [15:0] m_lfsr = SEED;

  pcie_tx_scrambler #(.LFSR_SEED(SEED)) dut (
    .clk_i              (clk_i),
    .rst_i              (rst_i),
    .bypass_scrambler_i (bypass_scrambler_i),
    .data_i             (data_i),
    .k_i                (k_i),
    .valid_i            (valid_i),
    .ready_o            (ready_o),
    .data_o             (data_o),
    .k_o                (k_o),
    .valid_o            (valid_o),
    .ready_i            (ready_i)
`ifdef PCIE_TX_SCRAMBLER_DBG_EN
    ,
    .lfsr_dbg_o         (lfsr_dbg_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #2_000_000;
    $display("FAIL global_timeout");
    $fatal(1, "bench timed out");
  end

  // Reference model and scoreboard; inputs and outputs are stable at the falling edge.
  always @(negedge clk_i) begin
    logic [8:0]  got, exp;
    logic [7:0]  s;
    logic [15:0] l;
    if (rst_i) begin
      sb_q.delete();
      m_lfsr = SEED;
    end else begin
      if (valid_o && ready_i) begin
        got = {k_o, data_o};
        log_q.push_back(got);
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL scoreboard_unexpected: got k=%0b data=%02h, expected no output", k_o, data_o);
        end else begin
          exp = sb_q.pop_front();
          if (got !== exp) begin
            errors++;
            $display("FAIL scoreboard: got k=%0b data=%02h, expected k=%0b data=%02h",
                     got[8], got[7:0], exp[8], exp[7:0]);
          end
        end
      end
      if (valid_i && ready_o) begin
        l = m_lfsr;
        s = 8'h00;
        for (int i = 0; i < 8; i++) begin
          s[i] = l[15];
          l = {l[14:0], 1'b0} ^ (l[15] ? 16'h0039 : 16'h0000);
        end
        if (k_i || bypass_scrambler_i) exp = {k_i, data_i};
        else                           exp = {1'b0, data_i ^ s};
        sb_q.push_back(exp);
        if (k_i && data_i == 8'hBC)      m_lfsr = SEED;
        else if (!(k_i && data_i == 8'h1C)) m_lfsr = l;
      end
    end
  end

  task automatic send(input logic k, input logic [7:0] d, input logic byp);
    int  n;
    logic acc;
    k_i = k;
    data_i = d;
    bypass_scrambler_i = byp;
    valid_i = 1'b1;
    n = 0;
    acc = 1'b0;
    do begin
      @(negedge clk_i);
      acc = ready_o;
      @(posedge clk_i);
      #1;
      n++;
    end while (!acc && n < 100);
    valid_i = 1'b0;
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL send_timeout: ready_o stayed %0b, required 1 within 100 cycles", ready_o);
    end
  endtask

  task automatic drain;
    int n;
    valid_i = 1'b0;
    n = 0;
    while ((sb_q.size() != 0 || valid_o) && n < 200) begin
      @(posedge clk_i);
      #1;
      n++;
    end
    checks++;
    if (sb_q.size() != 0 || valid_o) begin
      errors++;
      $display("FAIL drain: %0d bytes pending, valid_o=%0b, required 0 pending", sb_q.size(), valid_o);
    end
  endtask

  task automatic test_reset;
    rst_i = 1'b1;
    ready_i = 1'b1;
    repeat (3) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    @(posedge clk_i);
    #1;
    checks++;
    if ({valid_o, ready_o, data_o, k_o} !== {1'b0, 1'b1, 8'h00, 1'b0}) begin
      errors++;
      $display("FAIL reset_state: valid=%0b ready=%0b data=%02h k=%0b, required 0 1 00 0",
               valid_o, ready_o, data_o, k_o);
    end
  endtask

  task automatic test_scramble;
    logic [8:0] exp[5];
    exp = '{9'h1BC, 9'h0FF, 9'h017, 9'h0C0, 9'h014};
    log_q.delete();
    send(1'b1, 8'hBC, 1'b0);
    checks++;
    if (valid_o !== 1'b1 || data_o !== 8'hBC || k_o !== 1'b1) begin
      errors++;
      $display("FAIL latency: valid=%0b data=%02h k=%0b one cycle after COM, required 1 BC 1",
               valid_o, data_o, k_o);
    end
    repeat (4) send(1'b0, 8'h00, 1'b0);
    drain();
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (log_q.size() <= i || log_q[i] !== exp[i]) begin
        errors++;
        $display("FAIL scramble_vec[%0d]: got %03h, required %03h", i,
                 (log_q.size() > i) ? log_q[i] : 9'h000, exp[i]);
      end
    end
  endtask

  task automatic test_skp;
    logic [8:0] exp[4];
    exp = '{9'h1BC, 9'h0FF, 9'h11C, 9'h017};
    log_q.delete();
    send(1'b1, 8'hBC, 1'b0);
    send(1'b0, 8'h00, 1'b0);
    send(1'b1, 8'h1C, 1'b0);
    send(1'b0, 8'h00, 1'b0);
    drain();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (log_q.size() <= i || log_q[i] !== exp[i]) begin
        errors++;
        $display("FAIL skp_vec[%0d]: got %03h, required %03h", i,
                 (log_q.size() > i) ? log_q[i] : 9'h000, exp[i]);
      end
    end
  endtask

  task automatic test_bypass;
    logic [8:0] exp[5];
    exp = '{9'h1BC, 9'h000, 9'h000, 9'h1BC, 9'h0FF};
    log_q.delete();
    send(1'b1, 8'hBC, 1'b0);
    send(1'b0, 8'h00, 1'b1);
    send(1'b0, 8'h00, 1'b1);
    send(1'b1, 8'hBC, 1'b0);
    send(1'b0, 8'h00, 1'b0);
    drain();
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (log_q.size() <= i || log_q[i] !== exp[i]) begin
        errors++;
        $display("FAIL bypass_vec[%0d]: got %03h, required %03h", i,
                 (log_q.size() > i) ? log_q[i] : 9'h000, exp[i]);
      end
    end
  endtask

  task automatic test_stall;
    logic [7:0] stream[10];
    logic [8:0] ref_q[$];
    logic       saw_low;
    stream = '{8'hBC, 8'h00, 8'h5A, 8'hA5, 8'h11, 8'hFF, 8'h3C, 8'h80, 8'h01, 8'h7E};
    log_q.delete();
    ready_i = 1'b1;
    for (int i = 0; i < 10; i++) send(i == 0, stream[i], 1'b0);
    drain();
    ref_q = log_q;
    log_q.delete();
    saw_low = 1'b0;
    fork
      begin
        for (int i = 0; i < 10; i++) send(i == 0, stream[i], 1'b0);
      end
      begin
        repeat (3) @(posedge clk_i);
        #1;
        ready_i = 1'b0;
        repeat (5) begin
          @(negedge clk_i);
          if (!ready_o) saw_low = 1'b1;
          @(posedge clk_i);
          #1;
        end
        ready_i = 1'b1;
      end
    join
    drain();
    checks++;
    if (saw_low !== 1'b1) begin
      errors++;
      $display("FAIL stall_ready: ready_o low during stall=%0b, required 1", saw_low);
    end
    checks++;
    if (log_q.size() != ref_q.size()) begin
      errors++;
      $display("FAIL stall_count: got %0d bytes, required %0d", log_q.size(), ref_q.size());
    end
    for (int i = 0; i < ref_q.size() && i < log_q.size(); i++) begin
      checks++;
      if (log_q[i] !== ref_q[i]) begin
        errors++;
        $display("FAIL stall_vec[%0d]: got %03h, required %03h", i, log_q[i], ref_q[i]);
      end
    end
  endtask

  task automatic test_reset_mid;
    send(1'b1, 8'hBC, 1'b0);
    send(1'b0, 8'h00, 1'b0);
    ready_i = 1'b0;
    send(1'b0, 8'h00, 1'b0);
    rst_i = 1'b1;
    #1;
    checks++;
    if (valid_o !== 1'b0 || ready_o !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid: valid=%0b ready=%0b during reset, required 0 1", valid_o, ready_o);
    end
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    ready_i = 1'b1;
    log_q.delete();
    send(1'b0, 8'h00, 1'b0);
    drain();
    checks++;
    if (log_q.size() != 1 || log_q[0] !== 9'h0FF) begin
      errors++;
      $display("FAIL reset_reseed: got %0d bytes first=%03h, required 1 byte 0FF", log_q.size(),
               (log_q.size() > 0) ? log_q[0] : 9'h000);
    end
  endtask

  task automatic test_back_to_back;
    logic done;
    logic [7:0] ksyms[4];
    ksyms = '{8'hBC, 8'h1C, 8'hF7, 8'hFB};
    done = 1'b0;
    fork
      begin
        send(1'b1, 8'hBC, 1'b0);
        for (int i = 0; i < 300; i++) begin
          if ($urandom_range(0, 9) == 0) send(1'b1, ksyms[$urandom_range(0, 3)], 1'b0);
          else send(1'b0, 8'($urandom_range(0, 255)), $urandom_range(0, 5) == 0);
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk_i);
          #1;
          ready_i = ($urandom_range(0, 3) != 0);
        end
        ready_i = 1'b1;
      end
    join
    ready_i = 1'b1;
    drain();
  endtask

`ifdef PCIE_TX_SCRAMBLER_DBG_EN
  task automatic test_dbg;
    logic [15:0] exp[4];
    exp = '{16'hFFFF, 16'hE817, 16'hE817, 16'hFFFF};
    ready_i = 1'b1;
    send(1'b1, 8'hBC, 1'b0);
    checks++;
    if (lfsr_dbg_o !== exp[0]) begin
      errors++;
      $display("FAIL dbg_com: got %04h, required %04h", lfsr_dbg_o, exp[0]);
    end
    send(1'b0, 8'h00, 1'b0);
    checks++;
    if (lfsr_dbg_o !== exp[1]) begin
      errors++;
      $display("FAIL dbg_adv: got %04h, required %04h", lfsr_dbg_o, exp[1]);
    end
    send(1'b1, 8'h1C, 1'b0);
    checks++;
    if (lfsr_dbg_o !== exp[2]) begin
      errors++;
      $display("FAIL dbg_skp: got %04h, required %04h", lfsr_dbg_o, exp[2]);
    end
    send(1'b1, 8'hBC, 1'b0);
    checks++;
    if (lfsr_dbg_o !== exp[3]) begin
      errors++;
      $display("FAIL dbg_reseed: got %04h, required %04h", lfsr_dbg_o, exp[3]);
    end
    drain();
  endtask
`endif

  initial begin
    test_reset();
`ifdef PCIE_TX_SCRAMBLER_DBG_EN
    checks++;
    if (lfsr_dbg_o !== SEED) begin
      errors++;
      $display("FAIL dbg_reset: got %04h, required %04h", lfsr_dbg_o, SEED);
    end
`endif
    test_scramble();
    test_skp();
    test_bypass();
    test_stall();
    test_reset_mid();
    test_back_to_back();
`ifdef PCIE_TX_SCRAMBLER_DBG_EN
    test_dbg();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
